// File: rtl/serial_word_adder_if.sv
// Handshake bundle for serial_word_adder: parallel operand upstream, sum/carry downstream.
// Latency: none (wires only).
// Backpressure: valid/ready on both sides; slave = adder, master = producer/consumer.
// Ports: up_valid/up_ready/up_a/up_b (operand side), down_valid/down_ready/down_sum/down_carry (result side).
interface serial_word_adder_if #(
    parameter int WIDTH = 8
);
    logic             up_valid;
    logic             up_ready;
    logic [WIDTH-1:0] up_a;
    logic [WIDTH-1:0] up_b;
    logic             down_valid;
    logic             down_ready;
    logic [WIDTH-1:0] down_sum;
    logic             down_carry;

    modport master (
        output up_valid, up_a, up_b, down_ready,
        input  up_ready, down_valid, down_sum, down_carry
    );

    modport slave (
        input  up_valid, up_a, up_b, down_ready,
        output up_ready, down_valid, down_sum, down_carry
    );
endinterface

// File: rtl/serial_word_adder.sv
// Bit-serial adder: captures two WIDTH-bit operands, adds them LSB first, one bit per cycle.
// Latency: acceptance edge T -> result valid after edge T+WIDTH; WIDTH+2 cycles per word minimum.
// Backpressure: result held in DONE until down_ready; up_ready only in IDLE, so busy input is ignored.
// Ports: clk (clock), rst (async active-low reset), bus (serial_word_adder_if.slave handshake bundle).
// WIDTH must match the WIDTH of the connected interface instance; legal range 2..32.
module serial_word_adder #(
    parameter int WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst,
    serial_word_adder_if.slave  bus
);

    // Counter is fixed at 5 bits, enough to index bit 31 of the widest legal word.
    localparam int             CW       = 5;
    localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic             r_down_carry;
    logic [CW-1:0]    r_cnt;

    logic             w_s;
    logic             w_carry_nxt;
    logic [CW-1:0]    w_cnt_inc;
    logic             w_last;
    logic             w_up_ready;
    logic             w_down_valid;

    // Full-adder slice on the current LSBs.
    assign w_s         = r_a[0] ^ r_b[0] ^ r_carry;
    assign w_carry_nxt = (r_a[0] & r_b[0]) | (r_carry & (r_a[0] ^ r_b[0]));

    // Ripple increment written out as toggle conditions, keeping the block free of adders.
    assign w_cnt_inc = {r_cnt[4] ^ (&r_cnt[3:0]),
                        r_cnt[3] ^ (&r_cnt[2:0]),
                        r_cnt[2] ^ (r_cnt[1] & r_cnt[0]),
                        r_cnt[1] ^ r_cnt[0],
                        ~r_cnt[0]};

    assign w_last = (r_cnt == CNT_LAST);

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and handshake decodes; both ready/valid depend on state only.
    always_comb begin
        w_state_nxt  = r_state;
        w_up_ready   = 1'b0;
        w_down_valid = 1'b0;
        case (r_state)
            IDLE: begin
                w_up_ready = 1'b1;
                if (bus.up_valid) begin
                    w_state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (w_last) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                w_down_valid = 1'b1;
                if (bus.down_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Datapath: operands and sum shift right together; sum bits enter at the top so
    // that after WIDTH shifts each bit sits at its own weight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_a          <= '0;
            r_b          <= '0;
            r_sum        <= '0;
            r_carry      <= 1'b0;
            r_down_carry <= 1'b0;
            r_cnt        <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.up_valid) begin
                        r_a     <= bus.up_a;
                        r_b     <= bus.up_b;
                        r_carry <= 1'b0;
                        r_cnt   <= '0;
                    end
                end
                SHIFT: begin
                    r_a     <= {1'b0, r_a[WIDTH-1:1]};
                    r_b     <= {1'b0, r_b[WIDTH-1:1]};
                    r_sum   <= {w_s, r_sum[WIDTH-1:1]};
                    r_carry <= w_carry_nxt;
                    r_cnt   <= w_cnt_inc;
                    if (w_last) begin
                        r_down_carry <= w_carry_nxt;
                    end
                end
                default: begin
                    // DONE holds everything so the result stays stable under backpressure.
                end
            endcase
        end
    end

    assign bus.up_ready   = w_up_ready;
    assign bus.down_valid = w_down_valid;
    assign bus.down_sum   = r_sum;
    assign bus.down_carry = r_down_carry;

endmodule

// File: tb/tb_serial_word_adder.sv
// Directed and random checks for serial_word_adder at WIDTH=8.
// Inputs are driven on the falling edge; outputs are sampled on the falling edge.
module tb_serial_word_adder;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    serial_word_adder_if #(.WIDTH(8)) bus();

    serial_word_adder #(.WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Counts edges until down_valid is seen, bounded.
    task automatic wait_done(output int cyc);
        cyc = 0;
        while (!bus.down_valid && cyc < 40) begin
            tick();
            cyc++;
        end
    endtask

    task automatic run_word(input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] es, input logic ec, input string tag);
        int cyc;
        bus.up_a       = a;
        bus.up_b       = b;
        bus.up_valid   = 1'b1;
        bus.down_ready = 1'b1;
        chk({tag, "_rdy_before"}, 32'(bus.up_ready), 32'd1);
        tick();
        bus.up_valid = 1'b0;
        bus.up_a     = ~a;
        bus.up_b     = ~b;
        chk({tag, "_busy"}, 32'(bus.up_ready), 32'd0);
        wait_done(cyc);
        chk({tag, "_latency"}, 32'(cyc), 32'd8);
        chk({tag, "_sum"}, 32'(bus.down_sum), 32'(es));
        chk({tag, "_carry"}, 32'(bus.down_carry), 32'(ec));
        tick();
        chk({tag, "_idle_rdy"}, 32'(bus.up_ready), 32'd1);
        chk({tag, "_idle_vld"}, 32'(bus.down_valid), 32'd0);
    endtask

    initial begin
        int           cyc;
        int           t_prev;
        int           seen;
        int           sent;
        int           recvd;
        logic [8:0]   q[$];
        logic [8:0]   exp9;
        logic [7:0]   ra_tab[2];
        logic [7:0]   rb_tab[2];

        bus.up_valid   = 1'b0;
        bus.up_a       = '0;
        bus.up_b       = '0;
        bus.down_ready = 1'b0;

        // Reset state.
        #12;
        chk("rst_up_ready", 32'(bus.up_ready), 32'd1);
        chk("rst_down_valid", 32'(bus.down_valid), 32'd0);
        chk("rst_down_sum", 32'(bus.down_sum), 32'd0);
        chk("rst_down_carry", 32'(bus.down_carry), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // First acceptance on the first edge after release, then the boundary sums.
        run_word(8'h0F, 8'h01, 8'h10, 1'b0, "0f_01");
        run_word(8'hFF, 8'h01, 8'h00, 1'b1, "ff_01");
        run_word(8'hFF, 8'hFF, 8'hFE, 1'b1, "ff_ff");
        run_word(8'h00, 8'h00, 8'h00, 1'b0, "00_00");

        // Backpressure: result must hold while down_ready is low; busy input ignored.
        bus.down_ready = 1'b0;
        bus.up_a       = 8'h5A;
        bus.up_b       = 8'h33;
        bus.up_valid   = 1'b1;
        tick();
        bus.up_valid = 1'b0;
        wait_done(cyc);
        chk("bp_latency", 32'(cyc), 32'd8);
        chk("bp_sum", 32'(bus.down_sum), 32'h8D);
        chk("bp_carry", 32'(bus.down_carry), 32'd0);
        bus.up_valid = 1'b1;
        bus.up_a     = 8'h77;
        bus.up_b     = 8'h99;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_hold_vld", 32'(bus.down_valid), 32'd1);
            chk("bp_hold_sum", 32'(bus.down_sum), 32'h8D);
            chk("bp_hold_carry", 32'(bus.down_carry), 32'd0);
            chk("bp_hold_rdy", 32'(bus.up_ready), 32'd0);
        end
        bus.up_valid   = 1'b0;
        bus.down_ready = 1'b1;
        tick();
        chk("bp_xfer_vld", 32'(bus.down_valid), 32'd0);
        chk("bp_xfer_rdy", 32'(bus.up_ready), 32'd1);
        tick();
        chk("bp_no_dup", 32'(bus.down_valid), 32'd0);

        // Reset mid-operation, once without and once with a live carry.
        ra_tab[0] = 8'hAA; rb_tab[0] = 8'h55;
        ra_tab[1] = 8'hFF; rb_tab[1] = 8'hFF;
        for (int k = 0; k < 2; k++) begin
            bus.down_ready = 1'b1;
            bus.up_a       = ra_tab[k];
            bus.up_b       = rb_tab[k];
            bus.up_valid   = 1'b1;
            tick();
            bus.up_valid = 1'b0;
            repeat (3) tick();
            #2;
            rst = 1'b0;
            #1;
            chk("midrst_up_ready", 32'(bus.up_ready), 32'd1);
            chk("midrst_down_valid", 32'(bus.down_valid), 32'd0);
            chk("midrst_down_carry", 32'(bus.down_carry), 32'd0);
            @(negedge clk);
            rst = 1'b1;
            run_word(8'h01, 8'h01, 8'h02, 1'b0, "after_rst");
        end

        // Busy drop: up_valid stays high with changing data during SHIFT.
        bus.down_ready = 1'b1;
        bus.up_a       = 8'h11;
        bus.up_b       = 8'h22;
        bus.up_valid   = 1'b1;
        tick();
        cyc = 0;
        while (!bus.down_valid && cyc < 40) begin
            bus.up_a = 8'($urandom);
            bus.up_b = 8'($urandom);
            tick();
            cyc++;
        end
        chk("busy_latency", 32'(cyc), 32'd8);
        chk("busy_sum", 32'(bus.down_sum), 32'h33);
        chk("busy_carry", 32'(bus.down_carry), 32'd0);

        // Back-to-back with both handshakes tied high: one result every 10 cycles.
        bus.up_a = 8'h03;
        bus.up_b = 8'h04;
        cyc    = 0;
        t_prev = -1;
        seen   = 0;
        while (seen < 4 && cyc < 100) begin
            tick();
            cyc++;
            if (bus.down_valid) begin
                chk("b2b_sum", 32'(bus.down_sum), 32'h07);
                if (t_prev >= 0) chk("b2b_period", 32'(cyc - t_prev), 32'd10);
                t_prev = cyc;
                seen++;
            end
        end
        chk("b2b_count", 32'(seen), 32'd4);
        bus.up_valid = 1'b0;
        cyc = 0;
        while (!bus.up_ready && cyc < 20) begin
            tick();
            cyc++;
        end
        chk("drain_idle", 32'(bus.up_ready), 32'd1);

        // Random traffic against a 9-bit reference sum, in order.
        sent  = 0;
        recvd = 0;
        cyc   = 0;
        while (recvd < 1000 && cyc < 60000) begin
            bus.up_valid   = (sent < 1000) ? 1'($urandom_range(0, 1)) : 1'b0;
            bus.up_a       = 8'($urandom);
            bus.up_b       = 8'($urandom);
            bus.down_ready = ($urandom_range(0, 3) != 0);
            if (bus.up_valid && bus.up_ready) begin
                q.push_back({1'b0, bus.up_a} + {1'b0, bus.up_b});
                sent++;
            end
            if (bus.down_valid && bus.down_ready) begin
                if (q.size() == 0) begin
                    chk("rand_unexpected", 32'd1, 32'd0);
                end else begin
                    exp9 = q.pop_front();
                    chk("rand_result", 32'({bus.down_carry, bus.down_sum}), 32'(exp9));
                end
                recvd++;
            end
            tick();
            cyc++;
        end
        chk("rand_recvd", 32'(recvd), 32'd1000);
        chk("rand_queue_empty", 32'(q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_word_adder.md
SERIAL_WORD_ADDER -- requirements
Module: serial_word_adder

Interface
REQ-001 Parameter: WIDTH, default 8, operand and sum width in bits; legal range 2..32.
REQ-002 clk  input  1  sole clock; all state updates on posedge clk.
REQ-003 rst  input  1  reset, asynchronous, active-low; state is cleared while rst is 0.
REQ-004 up_valid  input  1  operand pair on up_a/up_b is valid.
REQ-005 up_ready  output  1  block can accept an operand pair.
REQ-006 up_a  input  WIDTH  operand A, parallel.
REQ-007 up_b  input  WIDTH  operand B, parallel.
REQ-008 down_valid  output  1  result on down_sum/down_carry is valid.
REQ-009 down_ready  input  1  consumer accepts the result.
REQ-010 down_sum  output  WIDTH  up_a + up_b modulo 2^WIDTH.
REQ-011 down_carry  output  1  carry out of bit WIDTH-1.

Function
REQ-012 FSM states: IDLE, SHIFT, DONE; reset state IDLE.
REQ-013 up_ready SHALL be 1 in IDLE only; down_valid SHALL be 1 in DONE only; both are registered-state decodes with no combinational path from up_valid or down_ready.
REQ-014 IDLE: on an edge with up_valid=1, capture up_a/up_b into operand shift registers, clear carry to 0, clear bit counter to 0, go to SHIFT.
REQ-015 SHIFT: each edge processes one bit, LSB first: s = a0 ^ b0 ^ carry; carry_next = (a0 & b0) | (carry & (a0 ^ b0)); operand registers shift right by one.
REQ-016 Bit-slice arithmetic SHALL use only ^, |, &, ~; no + operator anywhere in the block.
REQ-017 Sum register shifts right with s entering at bit WIDTH-1, so after WIDTH shifts bit i holds the sum bit of weight 2^i.
REQ-018 The bit counter increments once per SHIFT edge; on the edge processing bit WIDTH-1, go to DONE and latch carry_next into down_carry.
REQ-019 Latency: acceptance edge T -> down_valid high after edge T+WIDTH, i.e. exactly WIDTH cycles in SHIFT.
REQ-020 DONE: down_sum/down_carry SHALL hold stable while down_valid=1 and down_ready=0, for any number of cycles.
REQ-021 DONE: on an edge with down_ready=1, go to IDLE; the next operand pair can be accepted no earlier than the following edge; the minimum period is WIDTH+2 cycles per word.
REQ-022 up_valid in SHIFT or DONE SHALL be ignored, with no capture and no state change; up_a/up_b may change freely after acceptance.
REQ-023 down_ready in IDLE or SHIFT SHALL be ignored.
REQ-024 down_sum and down_carry outside DONE SHALL be don't-care for the consumer; the implementation holds the last result until the next acceptance.

Reset
REQ-025 rst=0 SHALL asynchronously force state IDLE, carry 0, counter 0, operand and sum registers 0, down_carry 0, up_ready 1, down_valid 0.
REQ-026 Reset asserted in any state, including mid-SHIFT, SHALL abort the operation with no result delivered; after release, the next accepted pair computes from carry 0.
REQ-027 The first acceptance is possible on the first posedge with rst=1 and up_valid=1.

Verification (WIDTH=8)
REQ-028 up_a=0x0F, up_b=0x01 accepted at edge T, down_ready=1 -> down_valid rises after edge T+8; down_sum=0x10, down_carry=0; IDLE after edge T+9.
REQ-029 up_a=0xFF, up_b=0x01 -> down_sum=0x00, down_carry=1; also 0xFF+0xFF -> 0xFE with carry 1, and 0x00+0x00 -> 0x00 with carry 0.
REQ-030 Backpressure: 0x5A+0x33 with down_ready=0 for 5 cycles in DONE -> down_sum=0x8D, down_carry=0, held stable; up_ready=0 throughout; one transfer when down_ready=1.
REQ-031 Reset mid-op: accept 0xAA+0x55, assert rst=0 after 3 SHIFT edges -> immediate IDLE, up_ready=1, down_valid=0; after release, 0x01+0x01 -> 0x02, carry 0, with no stale carry.
REQ-032 Busy drop: up_valid held at 1 with changing data during SHIFT -> only the first pair is summed; back-to-back words with up_valid and down_ready tied to 1 -> one result per 10 cycles.
REQ-033 Random: 1000 pairs with random up_valid/down_ready -> every {down_carry, down_sum} equals the 9-bit up_a+up_b from the reference model, in order, none lost or duplicated.
